// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline boundary register with 2-entry skid, hold and flush.
// Optional PIPE_STAGE_PERF_EN adds stall/bubble performance counters.
module pipe_stage_reg #(
    parameter int DATA_W = 175,
    parameter int CTRL_W = 11,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              hold,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic              acc, rel;
    assign in_ready  = state_q != TWO;
    assign out_valid = state_q != EMPTY;
    assign acc       = in_valid & in_ready;
    assign rel       = out_valid & out_ready & ~hold;
    assign out_data  = main_data_q;
    // Bubbles never expose stale control bits downstream
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (acc) begin
                    state_d     = ONE;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
                ONE: if (acc && rel) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (rel) begin
                    state_d = EMPTY;
                end else if (acc) begin
                    state_d     = TWO;
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end
                TWO: if (rel) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_q, bubble_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_q + CNT_W'(out_valid & (hold | ~out_ready));
            bubble_q <= bubble_q + CNT_W'(~out_valid);
        end
    end
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif
endmodule
